ct_seq_ctrl: RTL and testbench

CT_SEQ_CTRL -- requirements
Module: ct_seq_ctrl

---
 rtl/ct_pkg.sv | 14 +
 rtl/ct_core.sv | 39 +++
 rtl/ct_seq_ctrl.sv | 112 +++++++++++
 tb/tb_ct_seq_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ct_pkg.sv
// Shared definitions for the sequenced counter: FSM state encodings and default widths.
package ct_pkg;

   localparam int unsigned W_DEF  = 3;
   localparam int unsigned RW_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_DONE = 2'b11
   } ct_state_e;

endpackage

// File: rtl/ct_core.sv
// W-bit counter register with synchronous load and enabled up/down stepping.
module ct_core
   import ct_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         down,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Load wins over stepping so a new run always starts from its initial value.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         q_d = down ? (q_q - W'(1)) : (q_q + W'(1));
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/ct_seq_ctrl.sv
// Run sequencer: IDLE/RUN/HOLD/DONE FSM driving a ct_core counter, with latched
// direction/limit and a saturating completed-run counter.
module ct_seq_ctrl
   import ct_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned RW = RW_DEF
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          start,
   input  logic          pause,
   input  logic          dir,
   input  logic [W-1:0]  lim,
   output logic [W-1:0]  q,
   output logic          busy,
   output logic          done,
   output logic [1:0]    state,
   output logic [RW-1:0] runs
);

   ct_state_e     state_q, state_d;
   logic          dir_q, dir_d;
   logic [W-1:0]  lim_q, lim_d;
   logic [RW-1:0] runs_q, runs_d;

   logic          core_load;
   logic [W-1:0]  core_load_val;
   logic          core_en;
   logic [W-1:0]  end_val;
   logic          at_end;

   ct_core #(
      .W (W)
   ) u_core (
      .clk      (clk),
      .clr      (clr),
      .load     (core_load),
      .load_val (core_load_val),
      .en       (core_en),
      .down     (dir_q),
      .q        (q)
   );

   assign end_val = dir_q ? '0 : lim_q;
   assign at_end  = (q == end_val);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         dir_q   <= 1'b0;
         lim_q   <= '0;
         runs_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         lim_q   <= lim_d;
         runs_q  <= runs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      lim_d   = lim_q;
      runs_d  = runs_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dir_d   = dir;
               lim_d   = lim;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (pause) begin
               state_d = ST_HOLD;
            end else if (at_end) begin
               state_d = ST_DONE;
            end
         end
         ST_HOLD: begin
            if (!pause) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (runs_q != '1) begin
               runs_d = runs_q + RW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter control: the load value uses the live dir/lim because they are
   // latched on the same edge that loads the counter.
   always_comb begin
      core_load     = (state_q == ST_IDLE) && start;
      core_load_val = dir ? lim : '0;
      core_en       = (state_q == ST_RUN) && !pause && !at_end;
   end

   always_comb begin
      busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
      done  = (state_q == ST_DONE);
      state = state_q;
      runs  = runs_q;
   end

endmodule

// File: tb/tb_ct_seq_ctrl.sv
// Directed bench for ct_seq_ctrl with hand-computed expectations per clock edge.
module tb_ct_seq_ctrl;

   logic       clk;
   logic       clr;
   logic       start, pause, dir;
   logic [2:0] lim;
   logic [2:0] q;
   logic       busy, done;
   logic [1:0] state;
   logic [7:0] runs;

   logic       start2, pause2, dir2;
   logic [2:0] lim2;
   logic [2:0] q2;
   logic       busy2, done2;
   logic [1:0] state2;
   logic [1:0] runs2;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   ct_seq_ctrl #(.W(3), .RW(8)) dut (
      .clk(clk), .clr(clr), .start(start), .pause(pause), .dir(dir), .lim(lim),
      .q(q), .busy(busy), .done(done), .state(state), .runs(runs)
   );

   ct_seq_ctrl #(.W(3), .RW(2)) dut2 (
      .clk(clk), .clr(clr), .start(start2), .pause(pause2), .dir(dir2), .lim(lim2),
      .q(q2), .busy(busy2), .done(done2), .state(state2), .runs(runs2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b0; start = 1'b0; pause = 1'b0; dir = 1'b0; lim = '0;
      start2 = 1'b0; pause2 = 1'b0; dir2 = 1'b0; lim2 = '0;
      tick(); tick();
      check("rst_q", q, 0);
      check("rst_state", state, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_runs", runs, 0);
      clr = 1'b1;
      tick();
      check("idle_hold_q", q, 0);

      // Up run, lim=5: q after edges 0..6 = 0,1,2,3,4,5,5; DONE after edge 6.
      start = 1'b1; dir = 1'b0; lim = 3'd5;
      for (int i = 0; i <= 6; i++) begin
         tick();
         start = 1'b0;
         check($sformatf("up_q_e%0d", i), q, (i < 5) ? i : 5);
         check($sformatf("up_st_e%0d", i), state, (i <= 5) ? 1 : 3);
         check($sformatf("up_done_e%0d", i), done, (i == 6) ? 1 : 0);
      end
      tick();
      check("up_idle", state, 0);
      check("up_done_clear", done, 0);
      check("up_runs", runs, 1);
      check("up_busy_idle", busy, 0);

      // Asynchronous reset mid-run at q=3.
      start = 1'b1; dir = 1'b0; lim = 3'd5;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      check("pre_clr_q", q, 3);
      #2 clr = 1'b0;
      #1;
      check("clr_q", q, 0);
      check("clr_state", state, 0);
      check("clr_busy", busy, 0);
      check("clr_runs", runs, 0);
      clr = 1'b1;
      tick();
      check("post_clr_state", state, 0);

      // Down run, lim=4, pause sampled at edges 3 and 4.
      start = 1'b1; dir = 1'b1; lim = 3'd4;
      tick(); start = 1'b0;
      check("dn_q_e0", q, 4);
      tick(); check("dn_q_e1", q, 3);
      tick(); check("dn_q_e2", q, 2);
      pause = 1'b1;
      tick();
      check("hold_q_e3", q, 2);
      check("hold_st_e3", state, 2);
      check("hold_busy_e3", busy, 1);
      tick();
      check("hold_q_e4", q, 2);
      check("hold_st_e4", state, 2);
      pause = 1'b0;
      tick();
      check("resume_q_e5", q, 2);
      check("resume_st_e5", state, 1);
      tick(); check("dn_q_e6", q, 1);
      tick(); check("dn_q_e7", q, 0);
      check("dn_done_e7", done, 0);
      tick();
      check("dn_done_e8", done, 1);
      check("dn_st_e8", state, 3);
      tick();
      check("dn_idle_e9", state, 0);
      check("dn_runs", runs, 1);

      // lim=0: one RUN cycle, one DONE cycle, then IDLE.
      start = 1'b1; dir = 1'b0; lim = 3'd0;
      tick(); start = 1'b0;
      check("z_st_e0", state, 1);
      check("z_q_e0", q, 0);
      tick();
      check("z_st_e1", state, 3);
      check("z_done_e1", done, 1);
      tick();
      check("z_st_e2", state, 0);
      check("z_runs", runs, 2);

      // Changing lim/dir and asserting start during RUN must not disturb the run.
      start = 1'b1; dir = 1'b0; lim = 3'd3;
      tick();
      check("ign_q_e0", q, 0);
      dir = 1'b1; lim = 3'd1;
      tick(); check("ign_q_e1", q, 1); check("ign_st_e1", state, 1);
      tick(); check("ign_q_e2", q, 2);
      tick(); check("ign_q_e3", q, 3); check("ign_st_e3", state, 1);
      start = 1'b0;
      tick(); check("ign_done_e4", done, 1);
      tick(); check("ign_idle_e5", state, 0); check("ign_runs", runs, 3);

      // start held high on the RW=2 instance, lim=1: period of 4 edges, runs saturates at 3.
      start2 = 1'b1; dir2 = 1'b0; lim2 = 3'd1;
      for (int e = 0; e < 20; e++) begin
         tick();
         case (e % 4)
            0: check($sformatf("bb_st_e%0d", e), state2, 1);
            1: check($sformatf("bb_st_e%0d", e), state2, 1);
            2: check($sformatf("bb_done_e%0d", e), done2, 1);
            default: begin
               check($sformatf("bb_st_e%0d", e), state2, 0);
               check($sformatf("bb_runs_e%0d", e), runs2, (e / 4 + 1 > 3) ? 3 : e / 4 + 1);
            end
         endcase
      end
      start2 = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
